// File: rtl/lsu_pkg.sv
// Shared widths, request size encodings and FSM state type for the load/store controller.
package lsu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ACC1,
    ACC2,
    CAP,
    RESP
  } state_t;

  // True when an access of the given size at the given byte offset spills into the next word.
  function automatic logic crosses(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_HALF: crosses = (off == 2'd3);
      SZ_WORD: crosses = (off != 2'd0);
      default: crosses = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response bus from the memory stage plus the SRAM port, bundled for the controller.
interface lsu_mem_ctrl_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [3:0]        mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Controller side
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_w_en, mem_addr, mem_wdata
  );

  // Pipeline + SRAM side
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_w_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store data/strobe shift into two words, and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        st_size,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_lo,
  output logic [DATA_W-1:0] st_hi,
  output logic [3:0]        st_strb_lo,
  output logic [3:0]        st_strb_hi,

  input  logic [1:0]        ld_size,
  input  logic [1:0]        ld_off,
  input  logic              ld_unsigned,
  input  logic [DATA_W-1:0] ld_lo,
  input  logic [DATA_W-1:0] ld_hi,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0]   st_masked;
  logic [3:0]          strb_base;
  logic [2*DATA_W-1:0] st_wide;
  logic [7:0]          strb_wide;
  logic [DATA_W-1:0]   ld_sh;
  logic                sign;

  always_comb begin
    st_masked = st_data;
    strb_base = 4'b1111;
    case (st_size)
      SZ_BYTE: begin
        st_masked = {24'h0, st_data[7:0]};
        strb_base = 4'b0001;
      end
      SZ_HALF: begin
        st_masked = {16'h0, st_data[15:0]};
        strb_base = 4'b0011;
      end
      default: ;
    endcase
    st_wide    = {32'h0, st_masked} << {st_off, 3'b000};
    strb_wide  = {4'h0, strb_base} << st_off;
    st_lo      = st_wide[DATA_W-1:0];
    st_hi      = st_wide[2*DATA_W-1:DATA_W];
    st_strb_lo = strb_wide[3:0];
    st_strb_hi = strb_wide[7:4];
  end

  always_comb begin
    ld_sh   = 32'({ld_hi, ld_lo} >> {ld_off, 3'b000});
    sign    = 1'b0;
    ld_data = ld_sh;
    case (ld_size)
      SZ_BYTE: begin
        sign    = ~ld_unsigned & ld_sh[7];
        ld_data = {{24{sign}}, ld_sh[7:0]};
      end
      SZ_HALF: begin
        sign    = ~ld_unsigned & ld_sh[15];
        ld_data = {{16{sign}}, ld_sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one request at a time into word-aligned SRAM accesses.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses in two; otherwise they are rejected.
module lsu_mem_ctrl
  import lsu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_ctrl_if.slave  bus
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  state_t state, state_nx;

  logic              accept;
  logic              req_cross;
  logic              req_bad;

  logic              we_q;
  logic              uns_q;
  logic              cross_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] wd_hi_q;
  logic [3:0]        strb_hi_q;
  logic [DATA_W-1:0] data1_q;
  logic [DATA_W-1:0] rdata_q;

  logic [3:0]        w_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [DATA_W-1:0] st_lo, st_hi;
  logic [3:0]        st_strb_lo, st_strb_hi;
  logic [DATA_W-1:0] ld_lo, ld_hi, ld_data;

  assign accept    = bus.req_valid && (state == IDLE);
  assign req_cross = crosses(bus.req_size, bus.req_addr[1:0]);
  assign req_bad   = (bus.req_size == SZ_ILL) || (req_cross && !SPLIT_EN);

  // On a crossing load the word captured in ACC2 is the low half of the pair.
  assign ld_lo = cross_q ? data1_q : bus.mem_rdata;
  assign ld_hi = cross_q ? bus.mem_rdata : '0;

  lsu_align u_align (
    .st_size     (bus.req_size),
    .st_off      (bus.req_addr[1:0]),
    .st_data     (bus.req_wdata),
    .st_lo       (st_lo),
    .st_hi       (st_hi),
    .st_strb_lo  (st_strb_lo),
    .st_strb_hi  (st_strb_hi),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .ld_lo       (ld_lo),
    .ld_hi       (ld_hi),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = req_bad ? RESP : ACC1;
      ACC1: begin
        if (cross_q)   state_nx = ACC2;
        else if (we_q) state_nx = RESP;
        else           state_nx = CAP;
      end
      ACC2:    state_nx = we_q ? RESP : CAP;
      CAP:     state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SRAM port is registered so each access state sees its address/strobes for the whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      cross_q     <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= SZ_BYTE;
      off_q       <= 2'd0;
      wd_hi_q     <= '0;
      strb_hi_q   <= '0;
      data1_q     <= '0;
      rdata_q     <= '0;
      w_en_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      w_en_q <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            cross_q <= req_cross;
            size_q  <= bus.req_size;
            off_q   <= bus.req_addr[1:0];
            err_q   <= req_bad;
            rdata_q <= '0;
            if (!req_bad) begin
              mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (bus.req_we) begin
                mem_wdata_q <= st_lo;
                w_en_q      <= st_strb_lo;
                wd_hi_q     <= st_hi;
                strb_hi_q   <= st_strb_hi;
              end
            end
          end
        end
        ACC1: begin
          if (cross_q) begin
            mem_addr_q <= mem_addr_q + ADDR_W'(4);
            if (we_q) begin
              mem_wdata_q <= wd_hi_q;
              w_en_q      <= strb_hi_q;
            end
          end
        end
        ACC2: if (!we_q) data1_q <= bus.mem_rdata;
        CAP:  rdata_q <= ld_data;
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = err_q && (state == RESP);
  assign bus.rsp_rdata = (state == RESP) ? rdata_q : '0;
  assign bus.mem_w_en  = w_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a registered-read byte-lane SRAM model.
module tb_lsu_mem_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem_arr [0:16383];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: read returns the pre-write contents one cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.mem_w_en[i])
        mem_arr[bus.mem_addr[15:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    bus.mem_rdata <= mem_arr[bus.mem_addr[15:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents a request for one cycle; returns at the negedge of cycle T+1.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [15:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(negedge clk);
    bus.req_valid    = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid starting at cycle T+start, then checks latency/err/data.
  task automatic wait_rsp(input string tag, input int start, input int lat,
                          input logic err, input logic [31:0] data);
    int t;
    t = 0;
    for (int c = start; c <= start + 8; c++) begin
      if (bus.rsp_valid) begin
        t = c;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"}, 32'(t), 32'(lat));
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
    chk({tag, "_data"}, bus.rsp_rdata, data);
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    for (int i = 0; i < 16384; i++) mem_arr[i] = 32'h0;
    bus.mem_rdata    = 32'h0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 16'h0;
    bus.req_wdata    = 32'h0;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_w_en", 32'(bus.mem_w_en), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;

    // SW aligned
    issue(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
    chk("sw_addr", 32'(bus.mem_addr), 32'h0010);
    chk("sw_w_en", 32'(bus.mem_w_en), 32'hF);
    chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("sw_busy", 32'(bus.req_ready), 32'd0);
    wait_rsp("sw", 1, 2, 1'b0, 32'h0);

    // SB then byte loads
    issue(1'b1, 2'd0, 1'b0, 16'h0013, 32'h000000A5);
    chk("sb_w_en", 32'(bus.mem_w_en), 32'h8);
    chk("sb_wdata", bus.mem_wdata, 32'hA5000000);
    wait_rsp("sb", 1, 2, 1'b0, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0);
    chk("lb_addr", 32'(bus.mem_addr), 32'h0010);
    chk("lb_w_en", 32'(bus.mem_w_en), 32'h0);
    wait_rsp("lb", 1, 3, 1'b0, 32'hFFFFFFA5);
    issue(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0);
    wait_rsp("lbu", 1, 3, 1'b0, 32'h000000A5);

    // Halfword loads
    issue(1'b1, 2'd2, 1'b0, 16'h0010, 32'h80017FFF);
    wait_rsp("sw2", 1, 2, 1'b0, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 16'h0012, 32'h0);
    wait_rsp("lh12", 1, 3, 1'b0, 32'hFFFF8001);
    issue(1'b0, 2'd1, 1'b1, 16'h0012, 32'h0);
    wait_rsp("lhu12", 1, 3, 1'b0, 32'h00008001);
    issue(1'b0, 2'd1, 1'b0, 16'h0010, 32'h0);
    wait_rsp("lh10", 1, 3, 1'b0, 32'h00007FFF);

    // SH at offset 1 (inside one word)
    issue(1'b1, 2'd1, 1'b0, 16'h0031, 32'h1234BEEF);
    chk("sh_w_en", 32'(bus.mem_w_en), 32'h6);
    chk("sh_wdata", bus.mem_wdata, 32'h00BEEF00);
    wait_rsp("sh", 1, 2, 1'b0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 16'h0030, 32'h0);
    wait_rsp("lw30", 1, 3, 1'b0, 32'h00BEEF00);

    // Bytes either side of the address wrap
    issue(1'b1, 2'd0, 1'b0, 16'hFFFF, 32'h00000034);
    wait_rsp("sb_ffff", 1, 2, 1'b0, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 16'h0000, 32'h00000082);
    wait_rsp("sb_0000", 1, 2, 1'b0, 32'h0);

`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b1, 2'd2, 1'b0, 16'h0013, 32'h11223344);
    chk("xsw_a1_addr", 32'(bus.mem_addr), 32'h0010);
    chk("xsw_a1_w_en", 32'(bus.mem_w_en), 32'h8);
    chk("xsw_a1_wdata", bus.mem_wdata, 32'h44000000);
    @(negedge clk);
    chk("xsw_a2_addr", 32'(bus.mem_addr), 32'h0014);
    chk("xsw_a2_w_en", 32'(bus.mem_w_en), 32'h7);
    chk("xsw_a2_wdata", bus.mem_wdata, 32'h00112233);
    wait_rsp("xsw", 2, 3, 1'b0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 16'h0013, 32'h0);
    wait_rsp("xlw", 1, 4, 1'b0, 32'h11223344);
    issue(1'b0, 2'd1, 1'b0, 16'hFFFF, 32'h0);
    chk("wrap_a1_addr", 32'(bus.mem_addr), 32'hFFFC);
    @(negedge clk);
    chk("wrap_a2_addr", 32'(bus.mem_addr), 32'h0000);
    wait_rsp("wrap_lh", 2, 4, 1'b0, 32'hFFFF8234);
`else
    issue(1'b1, 2'd2, 1'b0, 16'h0013, 32'h11223344);
    chk("xsw_w_en", 32'(bus.mem_w_en), 32'h0);
    wait_rsp("xsw", 1, 1, 1'b1, 32'h0);
    chk("xsw_w_en_after", 32'(bus.mem_w_en), 32'h0);
    issue(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
    wait_rsp("xsw_nowrite", 1, 3, 1'b0, 32'h80017FFF);
    issue(1'b0, 2'd1, 1'b0, 16'hFFFF, 32'h0);
    wait_rsp("wrap_lh", 1, 1, 1'b1, 32'h0);
`endif

    // Illegal size
    issue(1'b1, 2'd3, 1'b0, 16'h0040, 32'hFFFFFFFF);
    chk("ill_w_en", 32'(bus.mem_w_en), 32'h0);
    wait_rsp("ill", 1, 1, 1'b1, 32'h0);

    // Reset in the middle of a store's ACC1
    issue(1'b1, 2'd2, 1'b0, 16'h0020, 32'hCAFEF00D);
    chk("rstop_w_en_pre", 32'(bus.mem_w_en), 32'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("rstop_w_en", 32'(bus.mem_w_en), 32'h0);
    chk("rstop_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("rstop_rsp_held", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstop_rsp_after", 32'(bus.rsp_valid), 32'd0);
    chk("rstop_ready_after", 32'(bus.req_ready), 32'd1);
    issue(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0);
    wait_rsp("rstop_nowrite", 1, 3, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller that sits between the CPU pipeline's memory stage and the byte-addressed `SRAM` block, acting as the initiator of the SRAM port. It accepts one byte, halfword or word load/store request at a time and converts it into word-aligned SRAM accesses with per-byte `w_en` strobes and lane-shifted write data. It sign- or zero-extends load data and returns a single-cycle response. An optional mode splits word-boundary-crossing accesses into two SRAM transactions.

## Interface
- No parameters. Address width is 16 and data width is 32, both fixed by the SRAM.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request; equals (state == IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`  in  1  zero-extend the load result (LBU/LHU); ignored for stores and words.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  access rejected; valid with `rsp_valid`.
- `mem_w_en`  out  4  SRAM byte write enables; lane i maps to address+i.
- `mem_addr`  out  16  SRAM address; always word-aligned (bits [1:0] = 0).
- `mem_wdata`  out  32  SRAM write data, lane-aligned.
- `mem_rdata`  in  32  SRAM read data, registered, valid one cycle after the address is presented.

## Operation
- **Handshake.**
  - A request is accepted when `req_valid && req_ready`.
  - Address, size, we, unsigned and wdata are captured on acceptance.
  - There is no response backpressure.
- **Address fields.**
  - off = `req_addr[1:0]`; A = {`req_addr[15:2]`, 2'b00}; n = 1, 2 or 4 bytes.
- **Crossing access.** An access crosses a word boundary when off + n > 4, i.e. half at off 3, or word at off ≠ 0.
- **Store lanes.**
  - 64-bit value = `req_wdata` masked to n bytes, shifted left by 8·off.
  - Low 32 bits plus lane mask go to access 1 at A.
  - High 32 bits plus lane mask go to access 2 at A+4, used only when crossing.
- **Load result.**
  - {data2, data1} >> 8·off, truncated to n bytes.
  - Sign-extended unless `req_unsigned`; words are unchanged.
- **Address arithmetic.** A+4 is computed modulo 2^16 (0xFFFC + 4 = 0x0000).
- **Illegal size (3).** No SRAM access; go directly to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
- **FSM states.** IDLE, ACC1, ACC2, CAP, RESP.
  - IDLE → ACC1 on accept. IDLE → RESP on illegal or rejected access.
  - ACC1: drive A plus strobes. Next state is ACC2 if crossing, else CAP for loads or RESP for stores.
  - ACC2: drive A+4 plus strobes; for loads, capture data1 from `mem_rdata`. Next state is CAP for loads, RESP for stores.
  - CAP: capture the final `mem_rdata` and form the result → RESP.
  - RESP: `rsp_valid` = 1 → IDLE.
- **Outside store access states.** `mem_w_en` = 0 in every state except store ACC1/ACC2. `mem_addr` holds its last value.

## Timing
- Acceptance is cycle T.
- Store, not crossing: SRAM write at the end of T+1; `rsp_valid` at T+2.
- Store, crossing: writes at T+1 and T+2; `rsp_valid` at T+3.
- Load, not crossing: address at T+1; data captured at T+2; `rsp_valid` and `rsp_rdata` at T+3.
- Load, crossing: addresses at T+1 and T+2; `rsp_valid` at T+4.
- Error: `rsp_valid` at T+1.
- The next request can be accepted in the cycle after RESP.
- Reset values: state IDLE, `req_ready` 1, `rsp_valid`/`rsp_err` 0, `rsp_rdata` 0, `mem_w_en` 0, `mem_addr` 0, `mem_wdata` 0.
- Reset mid-operation:
  - `mem_w_en` clears asynchronously, so no write commits at the following edge.
  - The pending request is dropped with no response.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: crossing accesses are split into two transactions as above; `rsp_err` is only set for size 3.
- Not defined: crossing accesses are rejected with no SRAM access. `rsp_err` = 1 and `rsp_valid` at T+1. ACC2 is unreachable and may be removed.

## Structure
- `lsu_pkg` holds:
  - the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD);
  - the state enum;
  - width constants ADDR_W = 16, DATA_W = 32.
- Sub-module `lsu_align` (combinational) holds:
  - the store lane shift and strobe generation;
  - load extract, shift and extension.
- The FSM and registers stay in `lsu_mem_ctrl`.

## Test plan
- **SW, aligned.** SW 0x0010 data 0xDEADBEEF → T+1: `mem_addr` 0x0010, `w_en` 4'b1111, `mem_wdata` 0xDEADBEEF. T+2: `rsp_valid` with `rsp_err` 0.
- **SB, then byte loads.** SB 0x0013 data 0x000000A5 → `w_en` 4'b1000, `mem_wdata` 0xA5000000. Then LB 0x0013 → 0xFFFFFFA5 at T+3; LBU 0x0013 → 0x000000A5.
- **Halfword loads.** SW 0x0010 data 0x80017FFF, then LH 0x0012 → 0xFFFF8001; LHU 0x0012 → 0x00008001; LH 0x0010 → 0x00007FFF.
- **Crossing SW, split enabled.** SW 0x0013 data 0x11223344:
  - ACC1: addr 0x0010, `w_en` 1000, wdata 0x44000000.
  - ACC2: addr 0x0014, `w_en` 0111, wdata 0x00112233.
  - `rsp` at T+3; LW 0x0013 then returns 0x11223344 at T+4.
- **Crossing SW, split disabled.** Same SW → `rsp_err` 1 at T+1, `w_en` never nonzero.
- **Wrap, split enabled.** LH 0xFFFF → addresses 0xFFFC then 0x0000.
- **Illegal size.** `req_size` = 3 → `rsp_err` 1 at T+1.
- **Reset during store.** `rst_n` low during a store's ACC1 → `w_en` 0 immediately, no `rsp_valid`, `req_ready` 1 after release.
